// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

    localparam int INS_W    = 32;
    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INS_W-1:0]    ins;
        logic [XLEN_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and decode-side signals of the fetch stage
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
);

    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ack;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             out_valid;
    logic [INS_W-1:0] out_ins;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_pcp4;
    logic             out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_ins, out_pc, out_pcp4,
        input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_ins, out_pc, out_pcp4,
        output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push/pop/flush holding fetched instructions
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   wdata,
    output entry_t                   rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction fetch FSM with queue; FETCH_BYPASS_EN adds zero-latency bypass
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h28),
    parameter int              PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [XLEN-1:0]  pc;
    } entry_t;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] redirect_target;
    entry_t          push_entry;
    entry_t          head;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            ack;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            full_next;
    logic            unused_bits;

    assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_bits     = ^bus.redirect_pc[1:0];
    assign ack             = bus.imem_ack && (state != IDLE);
    assign pop             = !empty && bus.out_ready && !bus.redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = empty && (state == REQ) && bus.imem_ack && !bus.redirect;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that decode takes straight away never enters the queue.
    assign push       = ack && (state == REQ) && !bus.redirect && !(bypass && bus.out_ready);
    assign full_next  = (count == CW'(DEPTH - 1)) && push && !pop;
    assign push_entry = '{ins: bus.imem_rdata, pc: fetch_pc};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The request is never withdrawn once raised; DISCARD keeps the old address until its ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc <= redirect_target;
                        state    <= REQ;
                    end else if (!full) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.redirect) begin
                        if (ack) begin
                            fetch_pc <= redirect_target;
                        end else begin
                            pending_pc <= redirect_target;
                            state      <= DISCARD;
                        end
                    end else if (ack) begin
                        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                        if (full_next) state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        fetch_pc <= bus.redirect ? redirect_target : pending_pc;
                        state    <= REQ;
                    end else if (bus.redirect) begin
                        pending_pc <= redirect_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state != IDLE);
    assign bus.imem_addr = fetch_pc;

`ifdef FETCH_BYPASS_EN
    assign bus.out_valid = !empty || bypass;
    assign bus.out_ins   = empty ? bus.imem_rdata : head.ins;
    assign bus.out_pc    = empty ? fetch_pc : head.pc;
`else
    assign bus.out_valid = !empty;
    assign bus.out_ins   = head.ins;
    assign bus.out_pc    = head.pc;
`endif
    assign bus.out_pcp4  = bus.out_pc + XLEN'(PC_STEP);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a queue-level model
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h28),
        .PC_STEP  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the queue as a list of {ins,pc}, the address of the current/next request,
    // whether a request is expected, and whether the outstanding response is to be thrown away.
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_ok     = 1'b0;
    bit          m_active = 1'b0;
    bit          m_stale  = 1'b0;
    logic [31:0] m_pc     = 32'h28;
    logic [31:0] m_pend   = 32'h0;

    always @(negedge clk) begin : model
        bit          ack;
        bit          pop;
        bit          byp;
        int          sz0;
        logic [31:0] rp;
        ack = bus.imem_ack && m_active;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (mq.size() == 0) && m_active && !m_stale && ack && !bus.redirect;
`endif
        if (m_ok) begin
            chk("req", 32'(bus.imem_req), 32'(m_active));
            if (m_active) chk("addr", bus.imem_addr, m_pc);
            chk("valid", 32'(bus.out_valid), 32'((mq.size() != 0) || byp));
            if (mq.size() != 0) begin
                chk("ins", bus.out_ins, mq[0].ins);
                chk("pc", bus.out_pc, mq[0].pc);
                chk("pcp4", bus.out_pcp4, mq[0].pc + 32'd4);
            end else if (byp) begin
                chk("byp_ins", bus.out_ins, bus.imem_rdata);
                chk("byp_pc", bus.out_pc, m_pc);
            end
        end
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_stale  = 1'b0;
            m_pc     = 32'h28;
            m_ok     = 1'b1;
        end else if (m_ok) begin
            sz0 = mq.size();
            if (bus.redirect) begin
                mq.delete();
                rp = {bus.redirect_pc[31:2], 2'b00};
                if (!m_active) begin
                    m_pc     = rp;
                    m_active = 1'b1;
                end else if (ack) begin
                    m_pc    = rp;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                    m_pend  = rp;
                end
            end else begin
                pop = (sz0 > 0) && bus.out_ready;
                if (pop) void'(mq.pop_front());
                if (!m_active) begin
                    m_active = (sz0 < DEPTH);
                end else if (ack && m_stale) begin
                    m_pc    = m_pend;
                    m_stale = 1'b0;
                end else if (ack) begin
                    if (!(byp && bus.out_ready)) mq.push_back('{ins: bus.imem_rdata, pc: m_pc});
                    m_pc     = m_pc + 32'd4;
                    m_active = (mq.size() < DEPTH);
                end
            end
        end
    end

    task automatic pre();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit a, input bit r, input bit rd, input logic [31:0] rpc, input bit rs);
        rst             = rs;
        bus.out_ready   = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ack    = a && (bus.imem_req === 1'b1);
        bus.imem_rdata  = bus.imem_addr ^ 32'hA5A5_0000;
        @(negedge clk);
    endtask

    task automatic do_reset();
        repeat (3) begin
            pre();
            apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        end
    endtask

    initial begin : main
        int          first_ack;
        int          last_ack;
        int          first_valid;
        int          n;
        bit          found;
        int          r_th;
        logic [31:0] addrs[$];
        logic [31:0] drained[$];

        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;

        do_reset();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);

        // Streaming with every request acked and decode always ready.
        first_ack = -1; last_ack = -1; first_valid = -1;
        for (int i = 0; i < 10; i++) begin
            pre();
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (bus.imem_req && bus.imem_ack) begin
                if (first_ack < 0) first_ack = i;
                last_ack = i;
                addrs.push_back(bus.imem_addr);
            end
            if (bus.out_valid && first_valid < 0) first_valid = i;
        end
        chk("t1_addr0", addrs[0], 32'h28);
        chk("t1_addr1", addrs[1], 32'h2C);
        chk("t1_addr2", addrs[2], 32'h30);
        chk("t1_addr3", addrs[3], 32'h34);
        chk("t1_b2b", 32'(last_ack - first_ack + 1), 32'(addrs.size()));
`ifdef FETCH_BYPASS_EN
        chk("t1_latency", 32'(first_valid), 32'(first_ack));
`else
        chk("t1_latency", 32'(first_valid), 32'(first_ack + 1));
`endif

        // Decode stalled: the queue fills to DEPTH and requests stop.
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            pre();
            apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (bus.imem_req && bus.imem_ack) n++;
        end
        chk("t2_acks", 32'(n), 32'd4);
        chk("t2_req_off", 32'(bus.imem_req), 32'd0);
        chk("t2_head", bus.out_pc, 32'h28);
        for (int i = 0; i < 4; i++) begin
            pre();
            apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (bus.out_valid) drained.push_back(bus.out_pc);
        end
        chk("t2_d0", drained[0], 32'h28);
        chk("t2_d1", drained[1], 32'h2C);
        chk("t2_d2", drained[2], 32'h30);
        chk("t2_d3", drained[3], 32'h34);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            pre();
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (bus.imem_req && bus.imem_ack) begin
                found = 1'b1;
                chk("t2_resume", bus.imem_addr, 32'h38);
            end
        end
        chk("t2_resume_seen", 32'(found), 32'd1);

        // Redirect while the request to 0x30 is outstanding; ack arrives 3 cycles later.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            pre();
            if (bus.imem_req && bus.imem_addr == 32'h30) begin
                apply(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
                found = 1'b1;
            end else begin
                apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            end
        end
        chk("t3_found", 32'(found), 32'd1);
        for (int k = 0; k < 3; k++) begin
            pre();
            apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("t3_hold_req", 32'(bus.imem_req), 32'd1);
            chk("t3_hold_addr", bus.imem_addr, 32'h30);
            chk("t3_no_valid", 32'(bus.out_valid), 32'd0);
        end
        pre();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_ack_addr", bus.imem_addr, 32'h30);
        chk("t3_ack_valid", 32'(bus.out_valid), 32'd0);
        pre();
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_dropped", 32'(bus.out_valid), 32'd0);
        chk("t3_new_addr", bus.imem_addr, 32'h100);

        // Redirect coinciding with ack and pop while two entries are queued.
        do_reset();
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            pre();
            apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (bus.imem_req && bus.imem_ack) n++;
        end
        pre();
        chk("t4_pre_addr", bus.imem_addr, 32'h30);
        apply(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
        chk("t4_valid_then", 32'(bus.out_valid), 32'd1);
        pre();
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_flushed", 32'(bus.out_valid), 32'd0);
        chk("t4_req", 32'(bus.imem_req), 32'd1);
        chk("t4_addr", bus.imem_addr, 32'h200);

        // Reset mid-stream with entries queued and a request outstanding.
        do_reset();
        n = 0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            pre();
            apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (bus.imem_req && bus.imem_ack) n++;
        end
        pre();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_outstanding", 32'(bus.imem_req), 32'd1);
        pre();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        pre();
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_req", 32'(bus.imem_req), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            pre();
            apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (bus.imem_req && bus.imem_ack) begin
                found = 1'b1;
                chk("t5_first", bus.imem_addr, 32'h28);
            end
        end
        chk("t5_first_seen", 32'(found), 32'd1);

        // Randomized traffic; the model process checks every cycle.
        r_th = 6;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) r_th = $urandom_range(0, 10);
            pre();
            apply(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < r_th),
                  ($urandom_range(0, 15) == 0),
                  $urandom,
                  ($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle instruction-fetch stage.
- Owns the PC and issues requests to an instruction memory with variable latency, using a req/ack handshake.
- Buffers fetched instructions in a DEPTH-entry queue and hands them to decode over a valid/ready interface.
- Supports PC redirect (branch/jump) with queue flush and discard of any in-flight response.

Parameters:
XLEN, 32, width of PC and addresses
DEPTH, 4, fetch queue entries; power of 2, at least 2
RESET_PC, 32'h28, PC loaded on reset (program entry point)
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address; held stable while imem_req=1 until ack
imem_ack  input  1  response valid; completes the outstanding request
imem_rdata  input  32  instruction word, valid when imem_ack=1
redirect  input  1  load new PC and flush (one-cycle pulse)
redirect_pc  input  XLEN  new PC; bits [1:0] ignored, forced to 00
out_valid  output  1  queue head valid
out_ins  output  32  queue head instruction
out_pc  output  XLEN  PC of the head instruction
out_pcp4  output  XLEN  out_pc + PC_STEP
out_ready  input  1  decode accepts the head

Behaviour:
- Reset is synchronous and active-high, on clk (decided). While rst=1:
  - state=IDLE, fetch_pc=RESET_PC, queue count=0, pointers=0
  - imem_req=0, out_valid=0; out_ins/out_pc/out_pcp4 are don't-care.
- First cycle after rst falls: REQ with imem_addr=RESET_PC.
- States: IDLE, REQ, DISCARD. At most one request outstanding.
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - ack=1: push {imem_rdata, fetch_pc}; fetch_pc += PC_STEP (wraps mod 2^XLEN).
  - After ack, next state is REQ if the post-cycle count < DEPTH, else IDLE. This allows back-to-back requests, one instruction per cycle throughput.
- IDLE: imem_req=0. Move to REQ when count < DEPTH.
- DISCARD:
  - imem_req=1, address still the old one (handshake is never withdrawn).
  - On ack: data dropped, go to REQ at the pending redirect PC.
- Redirect in REQ without ack: pending_pc=redirect_pc, go to DISCARD; the queue flushes this cycle.
- Redirect in REQ with ack the same cycle: response dropped, flush; next cycle REQ at redirect_pc.
- Redirect in IDLE: fetch_pc=redirect_pc, flush, go to REQ.
- Redirect in DISCARD: pending_pc overwritten (last wins). If ack arrives the same cycle, go to REQ at the new pc.
- Redirect has priority over pop: a pop in the same cycle is ignored, and count becomes 0.
- Pop occurs when out_valid & out_ready. Push and pop in the same cycle leave count unchanged. Push while full cannot occur, because no request is issued unless count < DEPTH.
- Output latency without bypass: ack at cycle t means out_valid at t+1 if the queue was empty. Queue order is FIFO.
- out_valid=0 whenever count=0.
- Pointers wrap mod DEPTH; count width is clog2(DEPTH)+1.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined, with count=0, state REQ, ack=1 and no redirect:
  - out_valid=1 combinationally that cycle, with out_ins=imem_rdata and out_pc=imem_addr.
  - If out_ready=1, the entry is consumed without being pushed; otherwise it is pushed as normal.
  - Latency drops from 1 cycle to 0.
- Undefined: no combinational path from imem_* to out_*; latency is 1 cycle as above.

Decomposition:
- Shared package:
  - state encoding enum (IDLE, REQ, DISCARD)
  - queue entry struct {ins[31:0], pc[XLEN-1:0]}
  - constant INS_W=32
- One natural sub-module: fetch_fifo, a parametrised synchronous FIFO with push/pop/flush, count, full/empty. It takes the same clk/rst.

Test Plan:
- Reset, then ack on every request with rdata=addr^32'hA5A5_0000, out_ready=1.
  - Required: addresses 0x28, 0x2C, 0x30… one per cycle.
  - out_pc tracks them and out_pcp4=out_pc+4.
  - First out_valid one cycle after the first ack.
- out_ready=0 with DEPTH=4.
  - Required: exactly 4 acks accepted, count=4, then imem_req=0.
  - Raising out_ready drains 0x28..0x34 in order, then requests resume at 0x38.
- Redirect to 0x100 while a request to 0x30 is outstanding, ack delayed 3 cycles.
  - Required: imem_addr stays 0x30 and imem_req stays high.
  - Ack data is dropped and out_valid=0 throughout.
  - Next request is 0x100.
- Redirect to 0x200 in the same cycle as ack and pop with 2 entries queued.
  - Required: queue empty next cycle and the response dropped.
  - Next imem_addr=0x200; redirect_pc=0x203 yields 0x200.
- Assert rst mid-stream with 3 entries queued and a request outstanding.
  - Required: next cycle out_valid=0 and imem_req=0.
  - After release, the first request is 0x28.
- With FETCH_BYPASS_EN, empty queue, out_ready=1, ack for 0x28.
  - Required: out_valid=1 and out_pc=0x28 in the ack cycle, count stays 0.
  - Without the macro: out_valid rises the next cycle.
